// File: rtl/fft_frame_sink_pkg.sv
// Shared definitions for the FFT frame sink: frame geometry, FSM encodings and the
// radix-4 digit-reversal helper used to form the replay address.
package fft_frame_sink_pkg;

    localparam int unsigned FrameLen = 1024;
    localparam int unsigned LastIdx  = FrameLen - 1;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WFill = 2'd1,
        WSkip = 2'd2
    } w_state_e;

    typedef enum logic {
        RIdle = 1'b0,
        RRun  = 1'b1
    } r_state_e;

    // Reverse the order of the base-4 digits in the low 'width' bits of addr
    // (width must be even). Digit 0 of the result is the top digit of addr.
    function automatic logic [15:0] digit_rev4(input logic [15:0] addr,
                                               input int unsigned width);
        logic [15:0] rev;
        rev = '0;
        for (int unsigned i = 0; i < width / 2; i++) begin
            rev[2*i +: 2] = addr[width - 2 - 2*i +: 2];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_frame_sink_bank_ram.sv
// Two-bank frame store: simple dual-port RAM, address = {bank, index}, with a
// registered (1-cycle latency) read port. Write and read ports are independent.
module fft_frame_sink_bank_ram #(
    parameter int unsigned WORDLENGTH = 32,
    parameter int unsigned ADDRLENGTH = 10
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDRLENGTH:0]   wr_addr_i,
    input  logic [WORDLENGTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDRLENGTH:0]   rd_addr_i,
    output logic [WORDLENGTH-1:0] rd_data_o
);

    localparam int unsigned Depth = 2 ** (ADDRLENGTH + 1);

    logic [WORDLENGTH-1:0] mem_q [Depth];
    logic [WORDLENGTH-1:0] rd_data_q;

    // Storage array and synchronous read register; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_frame_sink.sv
// FFT output frame sink: captures 1024-word frames into a ping-pong buffer and
// replays each frame in natural order over valid/ready, with a 2-entry skid behind
// the synchronous RAM read so the stream stays back-to-back while m_ready is high.
module fft_frame_sink
    import fft_frame_sink_pkg::*;
#(
    parameter int unsigned WORDLENGTH = 32,
    parameter int unsigned ADDRLENGTH = 10,
    parameter bit          DIGIT_REV  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sync_i,
    input  logic [WORDLENGTH-1:0] data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORDLENGTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic                  overflow
);

    localparam logic [ADDRLENGTH-1:0] LastWord = ADDRLENGTH'(LastIdx);

    // Write side
    w_state_e              w_state_q, w_state_d;
    logic                  wbank_q, wbank_d;
    logic [ADDRLENGTH-1:0] wcnt_q, wcnt_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_en;
    logic [ADDRLENGTH-1:0] wr_idx;
    logic                  set_full;

    // Bank occupancy, shared by both FSMs
    logic [1:0]            full_q, full_d;

    // Read side; rcnt has one extra bit that marks "all reads issued"
    r_state_e              r_state_q, r_state_d;
    logic                  rbank_q, rbank_d;
    logic [ADDRLENGTH:0]   rcnt_q, rcnt_d;
    logic                  clr_full;
    logic                  rd_en;
    logic [ADDRLENGTH-1:0] rd_idx;
    logic [ADDRLENGTH-1:0] rd_addr;
    logic [WORDLENGTH-1:0] ram_rdata;

    // RAM output stage tag: word present on ram_rdata this cycle
    logic                  ram_vld_q, ram_vld_d;
    logic                  ram_sof_q, ram_sof_d;
    logic                  ram_eof_q, ram_eof_d;

    // Skid FIFO
    logic [WORDLENGTH-1:0] skid_data_q [2];
    logic [WORDLENGTH-1:0] skid_data_d [2];
    logic [1:0]            skid_sof_q, skid_sof_d;
    logic [1:0]            skid_eof_q, skid_eof_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    logic                  skid_head_q, skid_head_d;

    logic                  skid_empty;
    logic                  out_valid;
    logic [WORDLENGTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eof;
    logic                  pop;

    // Write FSM: only cycles with enable=1 advance; sync_i always restarts a frame.
    always_comb begin
        w_state_d  = w_state_q;
        wbank_d    = wbank_q;
        wcnt_d     = wcnt_q;
        overflow_d = 1'b0;
        set_full   = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = wcnt_q;
        if (enable) begin
            unique case (w_state_q)
                WIdle, WSkip: begin
                    if (sync_i) begin
                        if (!full_q[wbank_q]) begin
                            wr_en     = 1'b1;
                            wr_idx    = '0;
                            wcnt_d    = ADDRLENGTH'(1);
                            w_state_d = WFill;
                        end else begin
                            overflow_d = 1'b1;
                            w_state_d  = WSkip;
                        end
                    end
                end
                WFill: begin
                    wr_en = 1'b1;
                    if (sync_i) begin
                        // Early resync: the partial frame is abandoned in place.
                        wr_idx = '0;
                        wcnt_d = ADDRLENGTH'(1);
                    end else if (wcnt_q == LastWord) begin
                        set_full  = 1'b1;
                        wbank_d   = ~wbank_q;
                        wcnt_d    = '0;
                        w_state_d = WIdle;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                default: w_state_d = WIdle;
            endcase
        end
    end

    // Write-side state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q  <= WIdle;
            wbank_q    <= 1'b0;
            wcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            wbank_q    <= wbank_d;
            wcnt_q     <= wcnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank flags: writer sets and reader clears can land in the same cycle on different banks.
    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d[wbank_q] = 1'b1;
        end
        if (clr_full) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    // Bank flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Output head: skid entry when present, otherwise the word straight off the RAM.
    always_comb begin
        skid_empty = (skid_cnt_q == 2'd0);
        out_valid  = !skid_empty || ram_vld_q;
        out_data   = skid_empty ? ram_rdata : skid_data_q[skid_head_q];
        out_sof    = skid_empty ? ram_sof_q : skid_sof_q[skid_head_q];
        out_eof    = skid_empty ? ram_eof_q : skid_eof_q[skid_head_q];
        pop        = out_valid && m_ready;
    end

    // Skid bookkeeping: a RAM word not consumed directly is parked at the tail.
    always_comb begin
        logic push;
        logic skid_pop;
        logic tail;
        skid_data_d = skid_data_q;
        skid_sof_d  = skid_sof_q;
        skid_eof_d  = skid_eof_q;
        skid_pop    = pop && !skid_empty;
        push        = ram_vld_q && !(skid_empty && pop);
        tail        = skid_head_q ^ skid_cnt_q[0];
        if (push) begin
            skid_data_d[tail] = ram_rdata;
            skid_sof_d[tail]  = ram_sof_q;
            skid_eof_d[tail]  = ram_eof_q;
        end
        skid_cnt_d  = skid_cnt_q + {1'b0, push} - {1'b0, skid_pop};
        skid_head_d = skid_head_q ^ skid_pop;
    end

    // Read FSM: a read is issued only if the skid will still have room when it lands.
    always_comb begin
        r_state_d = r_state_q;
        rbank_d   = rbank_q;
        rcnt_d    = rcnt_q;
        clr_full  = 1'b0;
        rd_en     = 1'b0;
        ram_vld_d = 1'b0;
        ram_sof_d = 1'b0;
        ram_eof_d = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                if (full_q[rbank_q]) begin
                    r_state_d = RRun;
                    rcnt_d    = '0;
                end
            end
            RRun: begin
                if (!rcnt_q[ADDRLENGTH] && (skid_cnt_d != 2'd2)) begin
                    rd_en     = 1'b1;
                    ram_vld_d = 1'b1;
                    ram_sof_d = (rcnt_q[ADDRLENGTH-1:0] == '0);
                    ram_eof_d = (rcnt_q[ADDRLENGTH-1:0] == LastWord);
                    rcnt_d    = rcnt_q + 1'b1;
                end
                if (pop && out_eof) begin
                    clr_full  = 1'b1;
                    rbank_d   = ~rbank_q;
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Read-side and skid state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= RIdle;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            ram_vld_q   <= 1'b0;
            ram_sof_q   <= 1'b0;
            ram_eof_q   <= 1'b0;
            skid_data_q <= '{default: '0};
            skid_sof_q  <= '0;
            skid_eof_q  <= '0;
            skid_cnt_q  <= '0;
            skid_head_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            ram_vld_q   <= ram_vld_d;
            ram_sof_q   <= ram_sof_d;
            ram_eof_q   <= ram_eof_d;
            skid_data_q <= skid_data_d;
            skid_sof_q  <= skid_sof_d;
            skid_eof_q  <= skid_eof_d;
            skid_cnt_q  <= skid_cnt_d;
            skid_head_q <= skid_head_d;
        end
    end

    assign rd_idx  = rcnt_q[ADDRLENGTH-1:0];
    assign rd_addr = DIGIT_REV ? ADDRLENGTH'(digit_rev4(16'(rd_idx), ADDRLENGTH)) : rd_idx;

    fft_frame_sink_bank_ram #(
        .WORDLENGTH(WORDLENGTH),
        .ADDRLENGTH(ADDRLENGTH)
    ) u_ram (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_addr_i({wbank_q, wr_idx}),
        .wr_data_i(data_in),
        .rd_en_i  (rd_en),
        .rd_addr_i({rbank_q, rd_addr}),
        .rd_data_o(ram_rdata)
    );

    // Gate payload with valid so the RAM's unreset contents never reach the port.
    assign m_valid  = out_valid;
    assign m_data   = out_valid ? out_data : '0;
    assign m_sof    = out_valid && out_sof;
    assign m_eof    = out_valid && out_eof;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Bench for fft_frame_sink: a linear and a digit-reversed instance share the same
// stimulus; expected words go into per-instance queues and a monitor compares.
module tb_fft_frame_sink;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        sync_i = 1'b0;
    logic [31:0] data_in = '0;
    logic        m_ready = 1'b1;
    logic [1:0]  m_valid, m_sof, m_eof, overflow;
    logic [31:0] m_data [2];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   sync_cyc = 0;
    int   first_cyc = 0;
    int   xfer [2] = '{0, 0};
    int   ovf_cnt [2] = '{0, 0};
    bit   prev_stall [2] = '{0, 0};
    bit   prev_ovf [2] = '{0, 0};
    logic [31:0] prev_d [2];
    logic prev_sof [2];
    logic prev_eof [2];
    bit   rdy_rand = 1'b0;
    logic rdy_fixed = 1'b1;
    exp_t sb [2][$];

    fft_frame_sink #(.WORDLENGTH(32), .ADDRLENGTH(10), .DIGIT_REV(1'b0)) dut_lin (
        .clk(clk), .rst(rst), .enable(enable), .sync_i(sync_i), .data_in(data_in),
        .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .m_sof(m_sof[0]), .m_eof(m_eof[0]), .overflow(overflow[0])
    );

    fft_frame_sink #(.WORDLENGTH(32), .ADDRLENGTH(10), .DIGIT_REV(1'b1)) dut_rev (
        .clk(clk), .rst(rst), .enable(enable), .sync_i(sync_i), .data_in(data_in),
        .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .m_sof(m_sof[1]), .m_eof(m_eof[1]), .overflow(overflow[1])
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [9:0] drev(input logic [9:0] r);
        return {r[1:0], r[3:2], r[5:4], r[7:6], r[9:8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int i);
        exp_t e;
        if (!rst) begin
            prev_stall[i] = 1'b0;
            prev_ovf[i]   = 1'b0;
            return;
        end
        if (prev_stall[i]) begin
            check($sformatf("stall_valid[%0d]", i), 32'(m_valid[i]), 32'd1);
            check($sformatf("stall_data[%0d]", i), m_data[i], prev_d[i]);
            check($sformatf("stall_sof[%0d]", i), 32'(m_sof[i]), 32'(prev_sof[i]));
            check($sformatf("stall_eof[%0d]", i), 32'(m_eof[i]), 32'(prev_eof[i]));
        end
        if (m_valid[i] && m_ready) begin
            if (sb[i].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word[%0d]: got %h, expected no output", i, m_data[i]);
            end else begin
                e = sb[i].pop_front();
                check($sformatf("data[%0d]", i), m_data[i], e.d);
                check($sformatf("sof[%0d]", i), 32'(m_sof[i]), 32'(e.sof));
                check($sformatf("eof[%0d]", i), 32'(m_eof[i]), 32'(e.eof));
                xfer[i]++;
            end
        end
        if (i == 0 && m_valid[0] && first_cyc < 0) first_cyc = cyc;
        if (overflow[i]) begin
            ovf_cnt[i]++;
            if (prev_ovf[i]) begin
                tests++;
                fails++;
                $display("FAIL overflow_width[%0d]: got 2+ cycle pulse, expected 1 cycle", i);
            end
        end
        prev_ovf[i]   = overflow[i];
        prev_stall[i] = m_valid[i] && !m_ready;
        prev_d[i]     = m_data[i];
        prev_sof[i]   = m_sof[i];
        prev_eof[i]   = m_eof[i];
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) mon(i);
    end

    // Downstream ready driver.
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        enable = 1'b0;
        sync_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input bit push,
                              input int gap_pct);
        for (int k = 0; k < n; k++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(0, 99) < gap_pct) begin
                    enable  = 1'b0;
                    sync_i  = 1'b0;
                    data_in = $urandom;
                    @(posedge clk);
                    #1;
                end
            end
            enable  = 1'b1;
            sync_i  = (k == 0);
            data_in = base + 32'(k);
            if (k == 0) sync_cyc = cyc;
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        sync_i = 1'b0;
        if (push) begin
            for (int r = 0; r < 1024; r++) begin
                sb[0].push_back('{d: base + 32'(r), sof: (r == 0), eof: (r == 1023)});
                sb[1].push_back('{d: base + {22'd0, drev(10'(r))}, sof: (r == 0),
                                  eof: (r == 1023)});
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        tests++;
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d/%0d words still pending, expected 0", name,
                     sb[0].size(), sb[1].size());
            sb[0].delete();
            sb[1].delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_valid[%0d]", name, i), 32'(m_valid[i]), 32'd0);
            check($sformatf("%s_data[%0d]", name, i), m_data[i], 32'd0);
            check($sformatf("%s_sof[%0d]", name, i), 32'(m_sof[i]), 32'd0);
            check($sformatf("%s_eof[%0d]", name, i), 32'(m_eof[i]), 32'd0);
            check($sformatf("%s_ovf[%0d]", name, i), 32'(overflow[i]), 32'd0);
        end
    endtask

    initial begin
        int ov [2];
        int tgt;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        idle(4);

        // Ramp frame, both address modes; latency sync -> first m_valid.
        first_cyc = -1;
        send_frame(1024, 32'd0, 1'b1, 0);
        wait_drain(3000, "ramp_drain");
        check("ramp_first_valid_latency", 32'(first_cyc - sync_cyc), 32'd1026);
        idle(8);

        // Two banks fill while stalled; third frame overflows and is dropped.
        ov[0] = ovf_cnt[0];
        ov[1] = ovf_cnt[1];
        rdy_fixed = 1'b0;
        idle(2);
        send_frame(1024, 32'h0001_0000, 1'b1, 0);
        idle(3);
        send_frame(1024, 32'h0002_0000, 1'b1, 0);
        idle(3);
        send_frame(1024, 32'h0003_0000, 1'b0, 0);
        idle(4);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ovf_pulses[%0d]", i), 32'(ovf_cnt[i] - ov[i]), 32'd1);
            check($sformatf("stalled_valid[%0d]", i), 32'(m_valid[i]), 32'd1);
            check($sformatf("stalled_head[%0d]", i), m_data[i], 32'h0001_0000);
            check($sformatf("stalled_sof[%0d]", i), 32'(m_sof[i]), 32'd1);
        end
        rdy_fixed = 1'b1;
        wait_drain(5000, "overflow_drain");
        idle(50);

        // Random backpressure and input gaps.
        rdy_rand = 1'b1;
        send_frame(1024, 32'h0004_0000, 1'b1, 25);
        send_frame(1024, 32'h0005_0000, 1'b1, 25);
        wait_drain(20000, "random_drain");
        rdy_rand = 1'b0;
        idle(8);

        // Early resync at wcnt=500: only the second frame appears, no overflow.
        ov[0] = ovf_cnt[0];
        ov[1] = ovf_cnt[1];
        send_frame(500, 32'h0006_0000, 1'b0, 0);
        send_frame(1024, 32'h0007_0000, 1'b1, 0);
        wait_drain(3000, "resync_drain");
        idle(4);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("resync_ovf[%0d]", i), 32'(ovf_cnt[i] - ov[i]), 32'd0);
        end

        // Reset mid-output, then a clean frame.
        tgt = xfer[0] + 300;
        send_frame(1024, 32'h0008_0000, 1'b1, 0);
        n = 0;
        while (xfer[0] < tgt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_word_300", 32'(xfer[0] >= tgt), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        sb[0].delete();
        sb[1].delete();
        @(posedge clk);
        #1;
        idle(3);
        rst = 1'b1;
        idle(4);
        send_frame(1024, 32'h0009_0000, 1'b1, 0);
        wait_drain(3000, "post_reset_drain");
        idle(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
